// File: rtl/traffic_pkg.sv
// Shared types for the intersection controller and the single-head light FSM.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } light_t;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
  } phase_t;

endpackage

// File: rtl/phase_timer.sv
// Saturating dwell counter; cleared on every phase entry.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (count != {CNT_W{1'b1}})
      count <= count + 1'b1;
  end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-approach intersection sequencer: NS main street, EW side street, latched walk request.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int MAIN_GREEN_MIN = 32,
  parameter int SIDE_GREEN     = 16,
  parameter int YELLOW_CYC     = 4,
  parameter int ALLRED_CYC     = 2,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       walk
);

  localparam logic [CNT_W-1:0] MAIN_LAST   = CNT_W'(MAIN_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] SIDE_LAST   = CNT_W'(SIDE_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);

  phase_t           phase, phase_nxt;
  logic [CNT_W-1:0] timer;
  logic             ped_pend, ped_served;
  logic             enter_ew;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (phase_nxt != phase),
    .count (timer)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= ALLRED_B;
      ped_pend   <= 1'b0;
      ped_served <= 1'b0;
    end else begin
      phase <= phase_nxt;
      // A press on the entry edge itself is served in this green, not the next.
      if (enter_ew) begin
        ped_served <= ped_pend | ped_req;
        ped_pend   <= 1'b0;
      end else begin
        ped_pend <= ped_pend | ped_req;
        if (phase_nxt != EW_GREEN)
          ped_served <= 1'b0;
      end
    end
  end

  always_comb begin
    phase_nxt = phase;
    ns_light  = RED;
    ew_light  = RED;
    walk      = 1'b0;
    case (phase)
      NS_GREEN: begin
        ns_light = GREEN;
        if (timer >= MAIN_LAST && (side_req || ped_pend)) phase_nxt = NS_YELLOW;
      end
      NS_YELLOW: begin
        ns_light = YELLOW;
        if (timer == YELLOW_LAST) phase_nxt = ALLRED_A;
      end
      ALLRED_A:  if (timer == ALLRED_LAST) phase_nxt = EW_GREEN;
      EW_GREEN: begin
        ew_light = GREEN;
        walk     = ped_served;
        if (timer == SIDE_LAST) phase_nxt = EW_YELLOW;
      end
      EW_YELLOW: begin
        ew_light = YELLOW;
        if (timer == YELLOW_LAST) phase_nxt = ALLRED_B;
      end
      ALLRED_B:  if (timer == ALLRED_LAST) phase_nxt = NS_GREEN;
      default:   phase_nxt = ALLRED_B;
    endcase
  end

  assign enter_ew = (phase_nxt == EW_GREEN) && (phase != EW_GREEN);

endmodule
